// File: rtl/fsm_chk_pkg.sv
// Shared types and defaults for the fsm response checker.
// The optional signature register is enabled by FSM_CHK_MISR_EN.
package fsm_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } chk_state_t;

    localparam int OUT_LEN_DEF = 19;
    localparam int DEPTH_DEF   = 118;
    localparam int IDX_W_DEF   = 7;

    // x^19 + x^5 + x^2 + x + 1, leading term implied by the shift-out bit
    localparam logic [18:0] MISR_TAPS = 19'h00027;

endpackage

// File: rtl/fsm_chk_misr.sv
// Galois-style multiple-input signature register over the DUT output bus.
// Only instantiated when FSM_CHK_MISR_EN is defined.
module fsm_chk_misr
    import fsm_chk_pkg::*;
#(
    parameter int W = OUT_LEN_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_sig
);

    localparam logic [W-1:0] TAPS = W'(MISR_TAPS);

    logic [W-1:0] r_sig;
    logic [W-1:0] w_fb;

    assign w_fb = r_sig[W-1] ? TAPS : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= {r_sig[W-2:0], 1'b0} ^ w_fb ^ i_din;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/fsm_resp_checker.sv
// Compares the DUT output stream against a preloaded expected/care memory.
// Define FSM_CHK_MISR_EN to build the output signature register.
module fsm_resp_checker
    import fsm_chk_pkg::*;
#(
    parameter int OUT_LEN = OUT_LEN_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int SKIP    = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_dut_rst,
    input  logic [OUT_LEN-1:0] i_dut_out,
    input  logic               i_exp_we,
    input  logic [IDX_W-1:0]   i_exp_addr,
    input  logic [OUT_LEN-1:0] i_exp_val,
    input  logic [OUT_LEN-1:0] i_exp_care,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [IDX_W:0]     o_err_cnt,
    output logic [IDX_W-1:0]   o_first_err_idx,
    output logic [OUT_LEN-1:0] o_first_err_got,
    output logic [OUT_LEN-1:0] o_sig
);

    localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 1) ? SKIP - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH);

    chk_state_t r_state;
    logic [SKIP_W-1:0] r_skip;
    logic [IDX_W-1:0] r_idx;
    logic r_busy;
    logic r_done;
    logic r_pass;
    logic [IDX_W:0] r_err_cnt;
    logic [IDX_W-1:0] r_first_idx;
    logic [OUT_LEN-1:0] r_first_got;

    // Each entry packs {care, value}
    logic [2*OUT_LEN-1:0] r_mem [DEPTH];

    logic w_idle_or_done;
    logic w_start_ok;
    logic w_we_ok;
    logic [2*OUT_LEN-1:0] w_entry;
    logic [OUT_LEN-1:0] w_val;
    logic [OUT_LEN-1:0] w_care;
    logic w_mismatch;

    assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
    assign w_start_ok = i_start && w_idle_or_done;
    assign w_we_ok = i_exp_we && w_idle_or_done
                     && ({1'b0, i_exp_addr} < DEPTH_V);

    always_ff @(posedge i_clk) begin
        if (w_we_ok) begin
            r_mem[i_exp_addr] <= {i_exp_care, i_exp_val};
        end
    end

    assign w_entry = r_mem[r_idx];
    assign w_val = w_entry[OUT_LEN-1:0];
    assign w_care = w_entry[2*OUT_LEN-1:OUT_LEN];
    assign w_mismatch = (|((i_dut_out ^ w_val) & w_care)) && !i_dut_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_skip <= '0;
            r_idx <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err_cnt <= '0;
            r_first_idx <= '0;
            r_first_got <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_state <= (SKIP == 0) ? RUN : ARM;
                        r_skip <= '0;
                        r_idx <= '0;
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_pass <= 1'b0;
                        r_err_cnt <= '0;
                        r_first_idx <= '0;
                        r_first_got <= '0;
                    end
                end
                ARM: begin
                    if (r_skip == SKIP_LAST) begin
                        r_state <= RUN;
                    end else begin
                        r_skip <= r_skip + 1'b1;
                    end
                end
                RUN: begin
                    if (w_mismatch) begin
                        if (r_err_cnt != '1) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        if (r_err_cnt == '0) begin
                            r_first_idx <= r_idx;
                            r_first_got <= i_dut_out;
                        end
                    end
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (r_err_cnt == '0) && !w_mismatch;
                    end
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_pass = r_pass;
    assign o_err_cnt = r_err_cnt;
    assign o_first_err_idx = r_first_idx;
    assign o_first_err_got = r_first_got;

`ifdef FSM_CHK_MISR_EN
    fsm_chk_misr #(
        .W(OUT_LEN)
    ) u_misr (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_clr(w_start_ok),
        .i_en (r_state == RUN),
        .i_din(i_dut_out),
        .o_sig(o_sig)
    );
`else
    assign o_sig = '0;
`endif

endmodule

// File: doc/fsm_resp_checker.md
# fsm_resp_checker

- Synthesizable response checker on the output side of the contest `fsm` harness.
- Consumes the DUT's `out` bus each cycle and compares it against a preloaded expected-response memory with per-bit care masks.
- Reports mismatch count, first-failure index and captured value, and a pass/done verdict.
- Pairs with the stimulus player that drives `{rst, in}`, so a bench or FPGA harness can self-check without a file-based golden compare.

## Interface

Parameters:
- `OUT_LEN`, 19 — width of the DUT output bus.
- `DEPTH`, 118 — number of expected entries, one per stimulus vector.
- `IDX_W`, 7 — index width; must satisfy 2^IDX_W ≥ DEPTH.
- `SKIP`, 1 — cycles between `start` and the first compare (DUT output latency).

Ports:
- `clk` in 1 — single clock; all logic on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — one-cycle pulse that begins a check run.
- `dut_rst` in 1 — the `rst` bit of the current stimulus vector; when high, that entry's compare is skipped.
- `dut_out` in OUT_LEN — DUT output sampled this cycle.
- `exp_we` in 1 — write strobe for the expected memory.
- `exp_addr` in IDX_W — write address.
- `exp_val` in OUT_LEN — expected value.
- `exp_care` in OUT_LEN — care mask; 1 = bit is checked.
- `busy` out 1 — high in ARM or RUN.
- `done` out 1 — high in DONE.
- `pass` out 1 — valid while `done`; 1 iff `err_cnt` == 0.
- `err_cnt` out IDX_W+1 — number of mismatching entries.
- `first_err_idx` out IDX_W — index of the first mismatch.
- `first_err_got` out OUT_LEN — `dut_out` captured at the first mismatch.
- `sig` out OUT_LEN — MISR signature (see Configuration).

## Operation

- States: IDLE, ARM, RUN, DONE.
- IDLE: `start` → ARM. Clears `err_cnt`, `first_err_*`, the index, the skip counter, and `sig`.
- ARM: counts SKIP−1 cycles, then enters RUN. With SKIP = 1, ARM lasts exactly one cycle. With SKIP = 0, IDLE goes directly to RUN and the compare starts on the cycle after `start`.
- RUN: every cycle, compare entry `idx`:
  - mismatch = |((`dut_out` ^ `exp_val`[idx]) & `exp_care`[idx]) and !`dut_rst`.
  - On mismatch: increment `err_cnt`, saturating at all-ones. If this is the first mismatch, latch `first_err_idx` = idx and `first_err_got` = `dut_out`.
  - Increment `idx`. After compare of idx = DEPTH−1 → DONE.
- DONE: `done` = 1 and `pass` is valid; results hold. `start` → ARM, with a full clear as in IDLE.
- `start` while in ARM or RUN is ignored.
- `exp_we` is honored only in IDLE or DONE; writes while `busy` are dropped. Addresses ≥ DEPTH are dropped.
- A zero care mask means the entry always passes.
- Expected memory contents are not cleared by `rst`; they are undefined until written.

## Timing

- Reset values: `busy` 0, `done` 0, `pass` 0, `err_cnt` 0, `first_err_idx` 0, `first_err_got` 0, `sig` 0. State is IDLE.
- `start` at cycle t:
  - `busy` rises at t+1.
  - First compare at t+1+SKIP.
  - `done` rises at t+1+SKIP+DEPTH, and `busy` falls in the same cycle.
- All outputs are registered. `err_cnt` and `first_err_*` update the cycle after the mismatching sample.
- Memory write: an entry written at cycle w is readable from cycle w+1.
- `rst` mid-run: returns to IDLE on the next edge, and all outputs return to their reset values.

## Configuration

- `FSM_CHK_MISR_EN` defined:
  - `sig` is an OUT_LEN-bit MISR (polynomial x^19+x^5+x^2+x+1, seed 0).
  - It folds in `dut_out` on every RUN cycle, including cycles where `dut_rst` is high.
  - It is cleared at `start` and frozen in DONE.
- Not defined: `sig` is tied to 0 and no MISR logic is generated.

## Structure

- Package `fsm_chk_pkg`:
  - state enum `chk_state_t` (IDLE, ARM, RUN, DONE);
  - default OUT_LEN, DEPTH, IDX_W;
  - MISR tap constant.
- Sub-module `fsm_chk_misr` (clk, rst, clr, en, din, sig), instantiated only under `FSM_CHK_MISR_EN`.
- Expected memory is an inferred array of 2×OUT_LEN bits (value and care) inside the top module.

## Test plan

- All-match: load 118 entries, care all-ones, feed identical `dut_out`, SKIP = 1, `start` at cycle 5 → `done` at cycle 125, `pass` = 1, `err_cnt` = 0.
- Single flip: bit 3 wrong at idx 40 → `err_cnt` = 1, `first_err_idx` = 40, `first_err_got` shows the flipped value, `pass` = 0.
- Masked and reset-skipped: a mismatch on a care = 0 bit at idx 10, plus a mismatch at idx 11 with `dut_rst` = 1 → `err_cnt` = 0.
- Multiple errors: mismatches at idx 7, 50, 117 → `err_cnt` = 3, `first_err_idx` = 7. A `start` pulse while `busy` changes nothing. An `exp_we` while `busy` leaves memory unchanged.
- Reset mid-run: `rst` at idx 60 → next cycle all outputs are 0 and the state is IDLE. A fresh `start` then completes normally.
- With `FSM_CHK_MISR_EN`: a constant `dut_out` of 0x00001 over 118 cycles → `sig` equals the model-computed value, and two identical runs give identical `sig`.
